// File: rtl/risc_cunit.sv
// Multi-cycle control unit for the 13-bit RISC core: sequences fetch, decode,
// ALU execute and register writeback, and tracks retired instructions.
module risc_cunit #(
    parameter int unsigned INSTR_W = 13,
    parameter int unsigned OPC_W   = 4,
    parameter int unsigned REG_AW  = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               stall,
    input  logic [INSTR_W-1:0] ir,
    output logic               fetch_en,
    output logic [REG_AW-1:0]  rs1_addr,
    output logic [REG_AW-1:0]  rs2_addr,
    output logic [OPC_W-1:0]   alu_op,
    output logic               alu_en,
    output logic               rf_we,
    output logic [REG_AW-1:0]  rf_waddr,
    output logic               busy,
    output logic               halted,
    output logic               illegal,
    output logic [CNT_W-1:0]   instr_count,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StFetch     = 3'd1,
        StDecode    = 3'd2,
        StExecute   = 3'd3,
        StWriteback = 3'd4,
        StHalt      = 3'd5
    } state_e;

    localparam logic [OPC_W-1:0] OpcNop     = '0;
    localparam logic [OPC_W-1:0] OpcIllegal = OPC_W'(14);
    localparam logic [OPC_W-1:0] OpcHalt    = OPC_W'(15);

    state_e             state_q, state_d;
    logic [OPC_W-1:0]   opcode_q, opcode_d;
    logic [REG_AW-1:0]  waddr_q, waddr_d;
    logic [REG_AW-1:0]  rs1_q, rs1_d;
    logic [REG_AW-1:0]  rs2_q, rs2_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OPC_W-1:0]   ir_opc;

    assign ir_opc = ir[INSTR_W-1 -: OPC_W];

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        waddr_d   = waddr_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        fetch_en  = 1'b0;
        alu_en    = 1'b0;
        rf_we     = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) state_d = StFetch;
            end
            StFetch: begin
                if (!stall) begin
                    fetch_en = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                if (!stall) begin
                    opcode_d = ir_opc;
                    waddr_d  = ir[3*REG_AW-1 -: REG_AW];
                    rs1_d    = ir[2*REG_AW-1 -: REG_AW];
                    rs2_d    = ir[REG_AW-1:0];
                    // Routing uses the live IR; the latched copy only feeds outputs.
                    if (ir_opc == OpcHalt) begin
                        state_d = StHalt;
                    end else if (ir_opc == OpcIllegal) begin
                        illegal_d = 1'b1;
                        state_d   = StFetch;
                    end else if (ir_opc == OpcNop) begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = stop ? StIdle : StFetch;
                    end else begin
                        state_d = StExecute;
                    end
                end
            end
            StExecute: begin
                if (!stall) begin
                    alu_en  = 1'b1;
                    state_d = StWriteback;
                end
            end
            StWriteback: begin
                if (!stall) begin
                    rf_we   = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = stop ? StIdle : StFetch;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            opcode_q  <= '0;
            waddr_q   <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            waddr_q   <= waddr_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign alu_op      = opcode_q;
    assign rf_waddr    = waddr_q;
    assign rs1_addr    = rs1_q;
    assign rs2_addr    = rs2_q;
    assign illegal     = illegal_q;
    assign instr_count = cnt_q;
    assign state       = state_q;
    assign busy        = (state_q != StIdle) && (state_q != StHalt);
    assign halted      = (state_q == StHalt);

endmodule
